// File: rtl/lsu_arbiter_if.sv
// Bundle between two LSU requesters, the arbiter and the shared LSU.
// The arbiter uses the slave view; the environment (requesters plus LSU) uses the master view.
interface lsu_arbiter_if;
  logic        m0_req_i;
  logic        m0_we_i;
  logic [3:0]  m0_byte_num_i;
  logic        m0_ld_us_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_wdata_i;
  logic        m0_gnt_o;
  logic        m0_rvalid_o;
  logic [31:0] m0_rdata_o;

  logic        m1_req_i;
  logic        m1_we_i;
  logic [3:0]  m1_byte_num_i;
  logic        m1_ld_us_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic        m1_gnt_o;
  logic        m1_rvalid_o;
  logic [31:0] m1_rdata_o;

  logic        lsu_sten_o;
  logic        lsu_ld_us_o;
  logic [3:0]  lsu_byte_num_o;
  logic [31:0] lsu_addr_o;
  logic [31:0] lsu_st_data_o;
  logic [31:0] lsu_ld_data_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_byte_num_i, m0_ld_us_i, m0_addr_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_req_i, m1_we_i, m1_byte_num_i, m1_ld_us_i, m1_addr_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output lsu_sten_o, lsu_ld_us_o, lsu_byte_num_o, lsu_addr_o, lsu_st_data_o,
    input  lsu_ld_data_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_byte_num_i, m0_ld_us_i, m0_addr_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_req_i, m1_we_i, m1_byte_num_i, m1_ld_us_i, m1_addr_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  lsu_sten_o, lsu_ld_us_o, lsu_byte_num_o, lsu_addr_o, lsu_st_data_o,
    output lsu_ld_data_i
  );
endinterface

// File: rtl/lsu_arbiter.sv
// Two-port arbiter in front of a single combinational LSU: grant, one access cycle, one
// response cycle. Round-robin or fixed priority on contention.
module lsu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input logic          clk_i,
  input logic          rst_i,
  lsu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        cmd_we_q, cmd_we_d;
  logic [3:0]  cmd_bn_q, cmd_bn_d;
  logic        cmd_us_q, cmd_us_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic        cmd_id_q, cmd_id_d;
  logic [31:0] rdata_q, rdata_d;
  logic        last_q, last_d;

  logic        gnt0, gnt1;
  logic        winner;

  always_comb begin
    state_d     = state_q;
    cmd_we_d    = cmd_we_q;
    cmd_bn_d    = cmd_bn_q;
    cmd_us_d    = cmd_us_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_id_d    = cmd_id_q;
    rdata_d     = rdata_q;
    last_d      = last_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    winner      = 1'b0;

    unique case (state_q)
      StIdle, StResp: begin
        state_d = StIdle;
        if (!rst_i && (bus.m0_req_i || bus.m1_req_i)) begin
          // On a tie the port that did not win last time goes next (last_q resets to 1).
          if (bus.m0_req_i && bus.m1_req_i) winner = RR_EN ? ~last_q : 1'b0;
          else                              winner = bus.m1_req_i;
          gnt0        = ~winner;
          gnt1        = winner;
          cmd_we_d    = winner ? bus.m1_we_i       : bus.m0_we_i;
          cmd_bn_d    = winner ? bus.m1_byte_num_i : bus.m0_byte_num_i;
          cmd_us_d    = winner ? bus.m1_ld_us_i    : bus.m0_ld_us_i;
          cmd_addr_d  = winner ? bus.m1_addr_i     : bus.m0_addr_i;
          cmd_wdata_d = winner ? bus.m1_wdata_i    : bus.m0_wdata_i;
          cmd_id_d    = winner;
          last_d      = winner;
          state_d     = StAccess;
        end
      end
      StAccess: begin
        rdata_d = bus.lsu_ld_data_i;
        state_d = StResp;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cmd_we_q    <= 1'b0;
      cmd_bn_q    <= 4'h0;
      cmd_us_q    <= 1'b0;
      cmd_addr_q  <= 32'h0;
      cmd_wdata_q <= 32'h0;
      cmd_id_q    <= 1'b0;
      rdata_q     <= 32'h0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      cmd_bn_q    <= cmd_bn_d;
      cmd_us_q    <= cmd_us_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_id_q    <= cmd_id_d;
      rdata_q     <= rdata_d;
      last_q      <= last_d;
    end
  end

  // LSU command comes only from registers, so it holds between accesses.
  assign bus.lsu_sten_o     = (state_q == StAccess) && cmd_we_q && !rst_i;
  assign bus.lsu_ld_us_o    = cmd_us_q;
  assign bus.lsu_byte_num_o = cmd_bn_q;
  assign bus.lsu_addr_o     = cmd_addr_q;
  assign bus.lsu_st_data_o  = cmd_wdata_q;

  assign bus.m0_gnt_o    = gnt0;
  assign bus.m1_gnt_o    = gnt1;
  assign bus.m0_rvalid_o = (state_q == StResp) && !cmd_id_q;
  assign bus.m1_rvalid_o = (state_q == StResp) && cmd_id_q;
  assign bus.m0_rdata_o  = rdata_q;
  assign bus.m1_rdata_o  = rdata_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench: a byte-addressed memory plus an input register at 0x900 model the LSU;
// a vector table drives the round-robin instance, a short sequence drives the fixed-priority one.
module tb_lsu_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  bn;
    logic        us;
    logic [31:0] addr;
    logic [31:0] wd;
  } cmd_t;

  // exp = {gnt0, gnt1, rvalid0, rvalid1, sten}
  typedef struct {
    logic        rst;
    cmd_t        m0;
    cmd_t        m1;
    logic [4:0]  exp;
    logic        chk_rd;
    logic [31:0] rd;
    logic        chk_lsu;
    logic [31:0] la;
    logic [3:0]  lbn;
  } vec_t;

  localparam cmd_t NC = '0;
  localparam logic [31:0] IoSw = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_arbiter_if ia ();
  lsu_arbiter_if ib ();

  lsu_arbiter #(.RR_EN(1'b1)) u_rr  (.clk_i(clk), .rst_i(rst), .bus(ia));
  lsu_arbiter #(.RR_EN(1'b0)) u_fix (.clk_i(clk), .rst_i(rst), .bus(ib));

  // LSU model for the round-robin instance: little-endian byte memory plus input register.
  logic [7:0]  mem [256];
  logic [7:0]  la;
  logic [31:0] lw;
  logic [31:0] ld_data;

  initial for (int i = 0; i < 256; i++) mem[i] <= 8'(i);

  always @(posedge clk) begin
    if (ia.lsu_sten_o) begin
      for (int i = 0; i < 4; i++) begin
        if (ia.lsu_byte_num_o[i]) mem[ia.lsu_addr_o[7:0] + 8'(i)] <= ia.lsu_st_data_o[8*i +: 8];
      end
    end
  end

  always_comb begin
    la = ia.lsu_addr_o[7:0];
    lw = {mem[la + 8'd3], mem[la + 8'd2], mem[la + 8'd1], mem[la]};
    ld_data = lw;
    if (ia.lsu_addr_o == 32'h900) begin
      ld_data = IoSw;
    end else if (ia.lsu_byte_num_o == 4'b0001) begin
      ld_data = ia.lsu_ld_us_o ? {24'h0, lw[7:0]} : {{24{lw[7]}}, lw[7:0]};
    end else if (ia.lsu_byte_num_o == 4'b0011) begin
      ld_data = ia.lsu_ld_us_o ? {16'h0, lw[15:0]} : {{16{lw[15]}}, lw[15:0]};
    end
  end
  assign ia.lsu_ld_data_i = ld_data;
  assign ib.lsu_ld_data_i = ~ib.lsu_addr_o;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic cmd_t ldw(input logic [31:0] a);
    return '{1'b1, 1'b0, 4'hF, 1'b0, a, 32'h0};
  endfunction
  function automatic cmd_t stw(input logic [31:0] a, input logic [31:0] d);
    return '{1'b1, 1'b1, 4'hF, 1'b0, a, d};
  endfunction
  function automatic cmd_t ldb(input logic [31:0] a, input logic us);
    return '{1'b1, 1'b0, 4'h1, us, a, 32'h0};
  endfunction
  function automatic cmd_t stb(input logic [31:0] a, input logic [31:0] d);
    return '{1'b1, 1'b1, 4'h1, 1'b0, a, d};
  endfunction

  task automatic drive_a(input cmd_t c0, input cmd_t c1);
    ia.m0_req_i = c0.req; ia.m0_we_i = c0.we; ia.m0_byte_num_i = c0.bn;
    ia.m0_ld_us_i = c0.us; ia.m0_addr_i = c0.addr; ia.m0_wdata_i = c0.wd;
    ia.m1_req_i = c1.req; ia.m1_we_i = c1.we; ia.m1_byte_num_i = c1.bn;
    ia.m1_ld_us_i = c1.us; ia.m1_addr_i = c1.addr; ia.m1_wdata_i = c1.wd;
  endtask

  task automatic drive_b(input cmd_t c0, input cmd_t c1);
    ib.m0_req_i = c0.req; ib.m0_we_i = c0.we; ib.m0_byte_num_i = c0.bn;
    ib.m0_ld_us_i = c0.us; ib.m0_addr_i = c0.addr; ib.m0_wdata_i = c0.wd;
    ib.m1_req_i = c1.req; ib.m1_we_i = c1.we; ib.m1_byte_num_i = c1.bn;
    ib.m1_ld_us_i = c1.us; ib.m1_addr_i = c1.addr; ib.m1_wdata_i = c1.wd;
  endtask

  vec_t v [36];
  logic [4:0] bexp [9];
  logic [4:0] act;

  initial begin
    drive_a(NC, NC);
    drive_b(NC, NC);

    v[0]  = '{1'b1, NC, NC, 5'b00000, 1'b1, 32'h0, 1'b1, 32'h0, 4'h0};
    // store/load word, port 0
    v[1]  = '{1'b0, stw(32'h10, 32'hDEADBEEF), NC, 5'b10000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0};
    v[2]  = '{1'b0, NC, NC, 5'b00001, 1'b0, 32'h0, 1'b1, 32'h10, 4'hF};
    v[3]  = '{1'b0, ldw(32'h10), NC, 5'b10100, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0};
    v[4]  = '{1'b0, NC, NC, 5'b00000, 1'b0, 32'h0, 1'b1, 32'h10, 4'hF};
    v[5]  = '{1'b0, NC, NC, 5'b00100, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 4'h0};
    // byte path, port 1
    v[6]  = '{1'b0, NC, stb(32'h5, 32'h80), 5'b01000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0};
    v[7]  = '{1'b0, NC, NC, 5'b00001, 1'b0, 32'h0, 1'b1, 32'h5, 4'h1};
    v[8]  = '{1'b0, NC, ldb(32'h5, 1'b0), 5'b01010, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0};
    v[9]  = '{1'b0, NC, ldb(32'h5, 1'b1), 5'b00000, 1'b0, 32'h0, 1'b1, 32'h5, 4'h1};
    v[10] = '{1'b0, NC, ldb(32'h5, 1'b1), 5'b01010, 1'b1, 32'hFFFFFF80, 1'b0, 32'h0, 4'h0};
    v[11] = '{1'b0, NC, NC, 5'b00000, 1'b0, 32'h0, 1'b1, 32'h5, 4'h1};
    v[12] = '{1'b0, NC, NC, 5'b00010, 1'b1, 32'h00000080, 1'b0, 32'h0, 4'h0};
    // input register
    v[13] = '{1'b0, ldw(32'h900), NC, 5'b10000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0};
    v[14] = '{1'b0, NC, NC, 5'b00000, 1'b0, 32'h0, 1'b1, 32'h900, 4'hF};
    v[15] = '{1'b0, NC, NC, 5'b00100, 1'b1, IoSw, 1'b0, 32'h0, 4'h0};
    // reset, then round-robin contention: 0,1,0,1
    v[16] = '{1'b1, ldw(32'h10), ldw(32'h4), 5'b00000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0};
    v[17] = '{1'b0, ldw(32'h10), ldw(32'h4), 5'b10000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0};
    v[18] = '{1'b0, ldw(32'h10), ldw(32'h4), 5'b00000, 1'b0, 32'h0, 1'b1, 32'h10, 4'hF};
    v[19] = '{1'b0, ldw(32'h10), ldw(32'h4), 5'b01100, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 4'h0};
    v[20] = '{1'b0, ldw(32'h10), ldw(32'h4), 5'b00000, 1'b0, 32'h0, 1'b1, 32'h4, 4'hF};
    v[21] = '{1'b0, ldw(32'h10), ldw(32'h4), 5'b10010, 1'b1, 32'h07068004, 1'b0, 32'h0, 4'h0};
    v[22] = '{1'b0, ldw(32'h10), ldw(32'h4), 5'b00000, 1'b0, 32'h0, 1'b1, 32'h10, 4'hF};
    v[23] = '{1'b0, ldw(32'h10), ldw(32'h4), 5'b01100, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 4'h0};
    v[24] = '{1'b0, NC, NC, 5'b00000, 1'b0, 32'h0, 1'b1, 32'h4, 4'hF};
    v[25] = '{1'b0, NC, NC, 5'b00010, 1'b1, 32'h07068004, 1'b0, 32'h0, 4'h0};
    // reset during the access of a store
    v[26] = '{1'b0, stw(32'h20, 32'h12345678), NC, 5'b10000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0};
    v[27] = '{1'b1, NC, NC, 5'b00000, 1'b0, 32'h0, 1'b1, 32'h20, 4'hF};
    v[28] = '{1'b0, NC, NC, 5'b00000, 1'b1, 32'h0, 1'b1, 32'h0, 4'h0};
    v[29] = '{1'b0, ldw(32'h20), NC, 5'b10000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0};
    v[30] = '{1'b0, NC, NC, 5'b00000, 1'b0, 32'h0, 1'b1, 32'h20, 4'hF};
    v[31] = '{1'b0, NC, NC, 5'b00100, 1'b1, 32'h23222120, 1'b0, 32'h0, 4'h0};
    // reset during a response
    v[32] = '{1'b0, NC, ldw(32'h10), 5'b01000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0};
    v[33] = '{1'b0, NC, NC, 5'b00000, 1'b0, 32'h0, 1'b1, 32'h10, 4'hF};
    v[34] = '{1'b1, ldw(32'h10), NC, 5'b00010, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 4'h0};
    v[35] = '{1'b0, NC, NC, 5'b00000, 1'b1, 32'h0, 1'b0, 32'h0, 4'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset st_data", ia.lsu_st_data_o, 32'h0);
    check("reset ld_us", {31'h0, ia.lsu_ld_us_o}, 32'h0);

    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      rst = v[i].rst;
      drive_a(v[i].m0, v[i].m1);
      #1;
      act = {ia.m0_gnt_o, ia.m1_gnt_o, ia.m0_rvalid_o, ia.m1_rvalid_o, ia.lsu_sten_o};
      check($sformatf("v%0d gnt0,gnt1,rv0,rv1,sten", i), {27'h0, act}, {27'h0, v[i].exp});
      if (v[i].chk_rd) begin
        check($sformatf("v%0d m0_rdata", i), ia.m0_rdata_o, v[i].rd);
        check($sformatf("v%0d m1_rdata", i), ia.m1_rdata_o, v[i].rd);
      end
      if (v[i].chk_lsu) begin
        check($sformatf("v%0d lsu_addr", i), ia.lsu_addr_o, v[i].la);
        check($sformatf("v%0d lsu_byte_num", i), {28'h0, ia.lsu_byte_num_o}, {28'h0, v[i].lbn});
      end
    end
    rst = 1'b0;
    drive_a(NC, NC);

    // Fixed priority: port 0 wins every tie until it stops requesting.
    bexp = '{5'b10000, 5'b00000, 5'b10100, 5'b00000, 5'b10100,
             5'b00000, 5'b01100, 5'b00000, 5'b00010};
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      drive_b((c < 5) ? ldw(32'h40) : NC, (c < 7) ? ldw(32'h44) : NC);
      #1;
      act = {ib.m0_gnt_o, ib.m1_gnt_o, ib.m0_rvalid_o, ib.m1_rvalid_o, ib.lsu_sten_o};
      check($sformatf("fix c%0d gnt0,gnt1,rv0,rv1,sten", c), {27'h0, act}, {27'h0, bexp[c]});
      if (c == 2) check("fix c2 m0_rdata", ib.m0_rdata_o, 32'hFFFFFFBF);
      if (c == 8) check("fix c8 m1_rdata", ib.m1_rdata_o, 32'hFFFFFFBB);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_arbiter.md
LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration on contention, 0 = fixed priority to port 0.
REQ-002 SHALL have one clock and a synchronous, active-high reset; ports and other signals are listed in REQ-003 to REQ-011.
REQ-003 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 mN_req_i  in  1  request from port N (N = 0, 1); held high until granted.
REQ-006 mN_we_i  in  1  1 = store, 0 = load.
REQ-007 mN_byte_num_i  in  4  byte mask (0001 byte, 0011 half, 1111 word); mN_ld_us_i  in  1  unsigned-load select.
REQ-008 mN_addr_i  in  32  byte address; mN_wdata_i  in  32  store data.
REQ-009 mN_gnt_o  out  1  request accepted this cycle; mN_rvalid_o  out  1  one-cycle response pulse; mN_rdata_o  out  32  load data, valid with rvalid.
REQ-010 lsu_sten_o  out  1; lsu_ld_us_o  out  1; lsu_byte_num_o  out  4; lsu_addr_o  out  32; lsu_st_data_o  out  32  (drive the shared LSU).
REQ-011 lsu_ld_data_i  in  32  combinational LSU load data for lsu_addr_o.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-013 SHALL accept a request only in IDLE or RESP: if any mN_req_i is high, select a winner, assert that port's mN_gnt_o combinationally in that cycle, and latch we/byte_num/ld_us/addr/wdata and the winner ID into a command register at the clock edge; next state ACCESS.
REQ-014 In IDLE or RESP with no request, next state SHALL be IDLE.
REQ-015 At most one mN_gnt_o SHALL be high in any cycle; gnt SHALL never be asserted in ACCESS.
REQ-016 With one requester, that port SHALL be granted.
REQ-017 With both requesting and RR_EN=1, the port not granted most recently SHALL win; a last-granted register (reset value 1) makes port 0 win the first tie after reset.
REQ-018 With RR_EN=0, port 0 SHALL always win ties; the last-granted register still updates but is ignored.
REQ-019 ACCESS lasts exactly one cycle and SHALL drive lsu_addr_o, lsu_byte_num_o, lsu_ld_us_o and lsu_st_data_o from the command register.
REQ-020 In ACCESS, lsu_sten_o SHALL equal the latched we AND NOT rst_i; outside ACCESS, lsu_sten_o SHALL be 0.
REQ-021 At the end of ACCESS, the arbiter SHALL register lsu_ld_data_i into a response-data register (stores: value is don't-care); next state RESP.
REQ-022 In RESP, mW_rvalid_o SHALL be 1 for exactly one cycle for the winner port W only, and mW_rdata_o SHALL equal the response-data register.
REQ-023 mN_rdata_o SHALL hold its value when rvalid is low; both ports SHALL share the response-data register.
REQ-024 Latency: gnt in cycle T, LSU access in T+1, rvalid in T+2.
REQ-025 A new grant in RESP SHALL give back-to-back throughput of one access per 2 cycles.
REQ-026 LSU command outputs other than sten SHALL hold their last value outside ACCESS; no combinational path SHALL exist from mN_* inputs to lsu_* outputs.
REQ-027 Requests changing while not granted SHALL have no effect; a request dropped before grant is not serviced.

Reset
REQ-028 When rst_i is high at a clock edge, the arbiter SHALL set state IDLE, command and response registers to 0, and last-granted to 1.
REQ-029 After reset: lsu_sten_o = 0, all gnt/rvalid = 0, all rdata/lsu_* outputs = 0.
REQ-030 Reset asserted while in ACCESS SHALL suppress lsu_sten_o in that cycle, produce no rvalid afterward, and drop the access.
REQ-031 Reset asserted in RESP SHALL drop the rvalid pulse from the following cycle onward; no gnt SHALL be asserted while rst_i is high.

Verification
REQ-032 Store then load, port 0: m0 store word 0xDEADBEEF @0x010, then load word @0x010 -> m0_gnt at T, lsu_sten_o=1 at T+1, m0_rvalid at T+2; load m0_rdata_o=0xDEADBEEF, m1_rvalid never high.
REQ-033 Contention, RR_EN=1: both ports request continuously for 4 grants -> grant order 0,1,0,1, gnt cycles 2 apart, each rvalid only on the granted port.
REQ-034 Contention, RR_EN=0: both ports request continuously -> m0 granted every time; m1 granted only after m0_req_i drops.
REQ-035 Byte path: m1 store byte 0x80 @0x005, then signed byte load -> m1_rdata_o=0xFFFFFF80; unsigned byte load -> 0x00000080; lsu_byte_num_o=0001 during ACCESS.
REQ-036 Reset mid-access: rst_i high during the ACCESS of a store word 0x12345678 @0x020 -> lsu_sten_o=0 that cycle, no rvalid; later load @0x020 returns the prior contents, not 0x12345678.
REQ-037 Input peripheral: m0 load word @0x900 with io_sw_i=0xA5A5A5A5 -> m0_rdata_o=0xA5A5A5A5 at T+2.
